// File: rtl/cpu_trace_emitter.sv
// Serializes one CPU write-back record into an ASCII trace frame, one character per transfer.
// First char 1 cycle after accept; char/char_valid hold while char_ready is low; in_ready only in IDLE.
module cpu_trace_emitter #(
  parameter int TIME_MAX = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        rec_type,
  input  logic [13:0] rec_time,
  input  logic [31:0] rec_pc,
  input  logic [31:0] rec_dst,
  input  logic [31:0] rec_data,
  output logic [7:0]  char,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        frame_done
);

  typedef enum logic [3:0] {
    IDLE, CARET, TIME, AT, PC, COLON, SP0, PREFIX,
    DST, SP1, LT, EQ, SP2, DATA, SHARP
  } state_t;

  state_t           state, nstate;
  logic [2:0]       cnt, ncnt;
  logic [7:0]       nchar;
  logic             xfer;

  logic             typ_q;
  logic [31:0]      pc_q, dst_q, data_q;
  logic [3:0][3:0]  tdig_q;
  logic [1:0]       tstart_q;

  logic [13:0]      t_sat;
  logic [3:0][3:0]  t_dig;
  logic [1:0]       t_start;
  logic [3:0]       r_tens, r_ones;

  function automatic logic [7:0] hex_c(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [7:0] dec_c(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  // Time is saturated and split into decimal digits once, at accept.
  assign t_sat    = (32'(rec_time) > TIME_MAX) ? 14'(TIME_MAX) : rec_time;
  assign t_dig[3] = 4'(t_sat / 14'd1000);
  assign t_dig[2] = 4'((t_sat / 14'd100) % 14'd10);
  assign t_dig[1] = 4'((t_sat / 14'd10) % 14'd10);
  assign t_dig[0] = 4'(t_sat % 14'd10);
  assign t_start  = (t_sat >= 14'd1000) ? 2'd3 :
                    (t_sat >= 14'd100)  ? 2'd2 :
                    (t_sat >= 14'd10)   ? 2'd1 : 2'd0;

  assign r_tens = 4'(dst_q[4:0] / 5'd10);
  assign r_ones = 4'(dst_q[4:0] % 5'd10);

  assign in_ready   = (state == IDLE);
  assign xfer       = char_valid && char_ready;
  assign frame_done = xfer && (state == SHARP);

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    if (state == IDLE) begin
      if (in_valid) nstate = CARET;
    end else if (xfer) begin
      case (state)
        CARET:  begin nstate = TIME; ncnt = {1'b0, tstart_q}; end
        TIME:   if (cnt == 3'd0) nstate = AT; else ncnt = cnt - 3'd1;
        AT:     begin nstate = PC; ncnt = 3'd7; end
        PC:     if (cnt == 3'd0) nstate = COLON; else ncnt = cnt - 3'd1;
        COLON:  nstate = SP0;
        SP0:    nstate = PREFIX;
        PREFIX: begin
          nstate = DST;
          ncnt   = typ_q ? 3'd7 : ((dst_q[4:0] >= 5'd10) ? 3'd1 : 3'd0);
        end
        DST:    if (cnt == 3'd0) nstate = SP1; else ncnt = cnt - 3'd1;
        SP1:    nstate = LT;
        LT:     nstate = EQ;
        EQ:     nstate = SP2;
        SP2:    begin nstate = DATA; ncnt = 3'd7; end
        DATA:   if (cnt == 3'd0) nstate = SHARP; else ncnt = cnt - 3'd1;
        SHARP:  nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  // Character for the state being entered, so char is registered alongside state.
  always_comb begin
    nchar = 8'h00;
    case (nstate)
      CARET:  nchar = "^";
      TIME:   nchar = dec_c(tdig_q[ncnt[1:0]]);
      AT:     nchar = "@";
      PC:     nchar = hex_c(pc_q[{ncnt, 2'b00} +: 4]);
      COLON:  nchar = ":";
      SP0, SP1, SP2: nchar = " ";
      PREFIX: nchar = typ_q ? "*" : "$";
      DST:    nchar = typ_q ? hex_c(dst_q[{ncnt, 2'b00} +: 4])
                            : dec_c(ncnt[0] ? r_tens : r_ones);
      LT:     nchar = "<";
      EQ:     nchar = "=";
      DATA:   nchar = hex_c(data_q[{ncnt, 2'b00} +: 4]);
      SHARP:  nchar = "#";
      default: nchar = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      char       <= 8'h00;
      char_valid <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      char       <= nchar;
      char_valid <= (nstate != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      typ_q    <= rec_type;
      pc_q     <= rec_pc;
      dst_q    <= rec_dst;
      data_q   <= rec_data;
      tdig_q   <= t_dig;
      tstart_q <= t_start;
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter; expected characters come from a string model via a queue.
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        rec_type;
  logic [13:0] rec_time;
  logic [31:0] rec_pc, rec_dst, rec_data;
  logic [7:0]  char;
  logic        char_valid;
  logic        char_ready;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = -1;
  logic [7:0] sb[$];

  cpu_trace_emitter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rec_type(rec_type), .rec_time(rec_time), .rec_pc(rec_pc),
    .rec_dst(rec_dst), .rec_data(rec_data), .char(char),
    .char_valid(char_valid), .char_ready(char_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string frame_str(input bit typ, input int tm, input logic [31:0] pc,
                                      input logic [31:0] dst, input logic [31:0] data);
    int t;
    string d;
    t = (tm > 9999) ? 9999 : tm;
    d = typ ? $sformatf("*%08h", dst) : $sformatf("$%0d", dst[4:0]);
    return $sformatf("^%0d@%08h: %s <= %08h#", t, pc, d, data);
  endfunction

  // Consumer side: every transfer pops one expected character.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      if (char_valid && char_ready) begin
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("char", char, e);
          check("frame_done", frame_done, 32'(e == "#"));
          if (frame_done) done_cyc = cyc;
        end
      end else begin
        check("frame_done_idle", frame_done, 0);
        if (!char_valid) check("char_zero", char, 0);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input bit typ, input int tm, input logic [31:0] pc,
                        input logic [31:0] dst, input logic [31:0] data,
                        input bit hold, output int acc_cyc);
    string s;
    int k;
    rec_type = typ; rec_time = 14'(tm); rec_pc = pc; rec_dst = dst; rec_data = data;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin step; k++; end
    check("accept_timeout", in_ready, 1);
    s = frame_str(typ, tm, pc, dst, data);
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    step;
    if (!hold) in_valid = 1'b0;
    acc_cyc = cyc;
    check("first_caret", char, "^");
    check("first_valid", char_valid, 1);
    check("busy_after_accept", in_ready, 0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || !in_ready) && k < 500) begin step; k++; end
    check(tag, 32'(sb.size() == 0 && in_ready), 1);
    check({tag, "_valid_low"}, char_valid, 0);
  endtask

  initial begin
    int acc, k, len_a;
    reset = 1'b1; in_valid = 1'b0; char_ready = 1'b1;
    rec_type = 1'b0; rec_time = '0; rec_pc = '0; rec_dst = '0; rec_data = '0;
    repeat (3) step;
    check("rst_char_valid", char_valid, 0);
    check("rst_char", char, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    step;

    // Register write, no backpressure: 29 back-to-back characters.
    accept(1'b0, 16, 32'h00003000, 32'd5, 32'h0000abcd, 1'b0, acc);
    wait_idle("t1_idle");
    check("t1_frame_cycles", 32'(done_cyc - acc), 28);

    // Memory write with lowercase hex.
    accept(1'b1, 0, 32'h00004ffc, 32'h00002ffc, 32'hdeadbeef, 1'b0, acc);
    wait_idle("t2_idle");
    check("t2_frame_cycles", 32'(done_cyc - acc), 34);

    // Saturation and register-index width.
    accept(1'b0, 12000, 32'h12345678, 32'd7, 32'hcafef00d, 1'b0, acc);
    wait_idle("t3_idle");
    accept(1'b0, 1234, 32'h0000a0b0, 32'hffffffe0, 32'h00000001, 1'b0, acc);
    wait_idle("t4_idle");
    accept(1'b0, 999, 32'hffffffff, 32'd31, 32'h89abcdef, 1'b0, acc);
    wait_idle("t5_idle");
    accept(1'b1, 9999, 32'h0, 32'h0a0b0c0d, 32'h0, 1'b0, acc);
    wait_idle("t5b_idle");

    // Backpressure while '@' is presented.
    char_ready = 1'b0;
    accept(1'b0, 16, 32'h00003000, 32'd5, 32'h0000abcd, 1'b0, acc);
    char_ready = 1'b1;
    repeat (3) step;
    char_ready = 1'b0;
    repeat (3) begin
      step;
      check("bp_hold_char", char, "@");
      check("bp_hold_valid", char_valid, 1);
    end
    char_ready = 1'b1;
    wait_idle("t6_idle");

    // Busy: in_valid held, data changed after accept.
    len_a = frame_str(1'b0, 42, 32'h00000100, 32'd12, 32'h11111111).len();
    accept(1'b0, 42, 32'h00000100, 32'd12, 32'h11111111, 1'b1, acc);
    rec_data = 32'h22222222;
    k = 0;
    while (!in_ready && k < 100) begin step; k++; end
    check("busy_cycles", k, len_a);
    accept(1'b0, 42, 32'h00000100, 32'd12, 32'h22222222, 1'b0, acc);
    wait_idle("t7_idle");

    // Reset in the middle of the data field.
    accept(1'b0, 16, 32'h00003000, 32'd5, 32'h0000abcd, 1'b0, acc);
    repeat (23) step;
    char_ready = 1'b0;
    reset = 1'b1;
    sb.delete();
    step;
    check("midrst_valid", char_valid, 0);
    check("midrst_char", char, 0);
    check("midrst_in_ready", in_ready, 1);
    reset = 1'b0;
    char_ready = 1'b1;
    step;
    accept(1'b1, 77, 32'h00000040, 32'hfedcba98, 32'h76543210, 1'b0, acc);
    wait_idle("t8_idle");

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_trace_emitter.md
Name: cpu_trace_emitter

Overview:
- Serializes one CPU write-back record per frame into the ASCII trace stream that the downstream trace checker parses.
- Sits directly upstream of the checker and feeds its char input.
- Accepts a parallel record over a valid/ready handshake, then emits one character per transfer.
- Register-write frame: "^<time>@<pc>: $<reg> <= <data>#". Memory-write frame: "^<time>@<pc>: *<addr> <= <data>#".

Parameters:
TIME_MAX, 9999, saturation ceiling for the decimal time field; must be at most 9999 so the field stays within 4 digits.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  record offered
in_ready  output  1  block can accept a record; high only in IDLE
rec_type  input  1  0 = register write ($), 1 = memory write (*)
rec_time  input  14  timestamp, unsigned
rec_pc  input  32  program counter
rec_dst  input  32  memory address (type 1); bits [4:0] are the register index (type 0)
rec_data  input  32  written data
char  output  8  current ASCII character; 8'h00 when char_valid is 0
char_valid  output  1  char holds a frame character
char_ready  input  1  consumer takes char this cycle
frame_done  output  1  one-cycle pulse in the cycle '#' is transferred

Behaviour:
- Reset (clk edge with reset=1): state IDLE, char_valid=0, char=8'h00, frame_done=0, in_ready=1. Any partial frame is discarded and never resumed.
- Accept: in_valid && in_ready at edge N latches every rec_* field. Later input changes have no effect on the frame.
- At N+1: char='^', char_valid=1, in_ready=0.
- Transfer: char_valid && char_ready at an edge advances to the next character.
- While char_ready=0, char and char_valid hold unchanged (no drop, no skip).
- Characters are registered outputs: a transfer at edge M presents the next character at M+1.
- States, in order: IDLE, CARET '^', TIME, AT '@', PC, COLON ':', SP0 ' ', PREFIX, DST, SP1 ' ', LT '<', EQ '=', SP2 ' ', DATA, SHARP '#'.
- PREFIX emits '$' for type 0 and '*' for type 1.
- TIME:
  - t = min(rec_time, TIME_MAX).
  - Decimal, MSB first, no leading zeros; 1 to 4 digits; t=0 emits "0".
  - A digit counter selects the first nonzero place.
- PC, DATA, and DST (type 1): always exactly 8 hex digits, lowercase a-f, MSB nibble first. A nibble counter runs 7 down to 0.
- DST (type 0): rec_dst[4:0] in decimal with no leading zeros; 1 or 2 digits (0..31). Bits [31:5] are ignored.
- Frame length:
  - Type 0: 26 + time digits + reg digits.
  - Type 1: 34 + time digits.
- SHARP:
  - Transfer of '#' pulses frame_done in the same cycle.
  - At the next cycle: IDLE, char_valid=0, char=8'h00, in_ready=1.
  - There is at least one idle cycle between frames; a record cannot be accepted in the '#' cycle.
- in_valid while in_ready=0 is ignored; the record is not queued.
- reset has priority over a simultaneous accept or transfer.
- No error checking on values (pc range, alignment, etc.); out-of-spec values are emitted verbatim so the checker flags them.

Test Plan:
- Reg write, char_ready=1: time=16, pc=32'h00003000, dst=5, data=32'h0000abcd -> "^16@00003000: $5 <= 0000abcd#". 29 consecutive valid chars starting 1 cycle after accept; frame_done on '#'; in_ready=1 the next cycle.
- Mem write: time=0, pc=32'h00004ffc, dst=32'h00002ffc, data=32'hdeadbeef -> "^0@00004ffc: *00002ffc <= deadbeef#" (35 chars). Hex is lowercase.
- Saturation and width: time=12000 emits "9999". time=1234, dst=32'hffffffe0 (reg index 0), type 0 -> "$0". dst=31 -> "$31".
- Backpressure: char_ready=0 for 3 cycles while '@' is presented -> char='@' and char_valid=1 held all 3 cycles. The following char is the first pc digit, no duplicates. Total frame unchanged.
- Busy and latching: in_valid=1 throughout the frame and rec_data changed mid-frame -> in_ready=0 until after '#'. The frame uses the data latched at accept. The next record is accepted only in IDLE.
- Reset mid-frame during DATA -> next cycle char_valid=0, char=8'h00, in_ready=1. A following record emits a complete fresh frame starting with '^'.
